// File: rtl/sddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sddr_pkg
// Description : Shared SDRAM/DDR controller definitions. It holds the geometry
//               constants used by the controller and its port arbiter, the
//               derived address/line widths, and the arbiter state encoding.
// Contents    : SDDR_BANK_BITS, SDDR_ROW_BITS, SDDR_COL_BITS, SDDR_DATA_BITS,
//               SDDR_BURST_LENGTH, SDDR_ADDRESS_BITS, SDDR_LINE_BITS,
//               arb_state_t
// Revision    : 1.0 - initial release
// ============================================================================
package sddr_pkg;

    // Device geometry defaults, shared with the controller.
    localparam int SDDR_BANK_BITS    = 3;
    localparam int SDDR_ROW_BITS     = 13;
    localparam int SDDR_COL_BITS     = 10;
    localparam int SDDR_DATA_BITS    = 16;
    localparam int SDDR_BURST_LENGTH = 8;

    // Byte address: bank + row + column + byte-select bits within one beat.
    localparam int SDDR_ADDRESS_BITS = SDDR_BANK_BITS + SDDR_ROW_BITS
                                     + SDDR_COL_BITS + $clog2(SDDR_DATA_BITS / 8);

    // One full burst is moved as a single line.
    localparam int SDDR_LINE_BITS    = SDDR_BURST_LENGTH * SDDR_DATA_BITS;

    // Port arbiter states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

endpackage : sddr_pkg
`default_nettype wire

// File: rtl/sddr_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : sddr_rr_picker
// Description : Combinational round-robin priority encoder. Searches the
//               request vector upward starting one position after the
//               pointer (wrapping) and returns the first requester found.
// Ports       : req       in  NUM_PORTS  request vector
//               ptr       in  PTR_BITS   last granted index
//               winner    out PTR_BITS   selected index (ptr when none)
//               any_valid out 1          at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module sddr_rr_picker #(
    parameter int NUM_PORTS = 3,
    parameter int PTR_BITS  = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_BITS-1:0]  ptr,
    output logic [PTR_BITS-1:0]  winner,
    output logic                 any_valid
);

    logic [PTR_BITS-1:0] w_idx;

    // The loop walks from the farthest candidate (ptr itself) down to the
    // nearest (ptr+1); the last match written therefore is the closest one
    // after the pointer, which gives round-robin priority without a
    // "found" flag or an early exit.
    always_comb begin
        winner    = ptr;
        any_valid = 1'b0;
        w_idx     = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_idx = PTR_BITS'((int'(ptr) + i) % NUM_PORTS);
            if (req[w_idx]) begin
                winner    = w_idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule : sddr_rr_picker
`default_nettype wire

// File: rtl/sddr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sddr_port_arbiter
// Description : Shares the DDR controller's single data command interface
//               between NUM_PORTS requesters. One port is granted at a time in
//               round-robin order; its command is forwarded downstream. A
//               read keeps the grant until its data returns, which is then
//               routed back to the owning port. A watchdog abandons reads
//               whose response never arrives and raises a sticky error.
// Ports       : cpu_clock_i        in   1                 clock
//               reset_n_i          in   1                 async active-low reset
//               req_valid_i        in   NUM_PORTS         per-port request valid
//               req_write_i        in   NUM_PORTS         per-port 1=write 0=read
//               req_address_i      in   NUM_PORTS*ADDR    per-port byte address
//               req_data_i         in   NUM_PORTS*LINE    per-port write payload
//               req_ack_o          out  NUM_PORTS         command accepted pulse
//               rsp_ready_o        out  NUM_PORTS         read data valid pulse
//               rsp_data_o         out  LINE              shared read data
//               data_cmd_valid_o   out  1                 downstream command valid
//               data_cmd_write_o   out  1                 downstream write flag
//               data_cmd_address_o out  ADDR              downstream address
//               data_cmd_data_o    out  LINE              downstream payload
//               data_cmd_ack_i     in   1                 downstream accept
//               data_rsp_ready_i   in   1                 downstream read data valid
//               data_rsp_data_i    in   LINE              downstream read data
//               grant_o            out  clog2(NUM_PORTS)  current/last grant
//               timeout_err_o      out  1                 sticky read timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module sddr_port_arbiter
    import sddr_pkg::*;
#(
    parameter int NUM_PORTS    = 3,
    parameter int ADDRESS_BITS = SDDR_ADDRESS_BITS,
    parameter int LINE_BITS    = SDDR_LINE_BITS,
    parameter int RSP_TIMEOUT  = 1023
) (
    input  logic                              cpu_clock_i,
    input  logic                              reset_n_i,
    input  logic [NUM_PORTS-1:0]              req_valid_i,
    input  logic [NUM_PORTS-1:0]              req_write_i,
    input  logic [NUM_PORTS*ADDRESS_BITS-1:0] req_address_i,
    input  logic [NUM_PORTS*LINE_BITS-1:0]    req_data_i,
    output logic [NUM_PORTS-1:0]              req_ack_o,
    output logic [NUM_PORTS-1:0]              rsp_ready_o,
    output logic [LINE_BITS-1:0]              rsp_data_o,
    output logic                              data_cmd_valid_o,
    output logic                              data_cmd_write_o,
    output logic [ADDRESS_BITS-1:0]           data_cmd_address_o,
    output logic [LINE_BITS-1:0]              data_cmd_data_o,
    input  logic                              data_cmd_ack_i,
    input  logic                              data_rsp_ready_i,
    input  logic [LINE_BITS-1:0]              data_rsp_data_i,
    output logic [$clog2(NUM_PORTS)-1:0]      grant_o,
    output logic                              timeout_err_o
);

    localparam int c_PTR_BITS = $clog2(NUM_PORTS);
    // A zero timeout disables the watchdog; keep a 1-bit counter so the
    // vector stays legal in that configuration.
    localparam int c_WD_BITS  = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
    localparam logic [c_WD_BITS-1:0] c_WD_LIMIT  = c_WD_BITS'(RSP_TIMEOUT);
    localparam bit                   c_WD_ENABLE = (RSP_TIMEOUT != 0);

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    arb_state_t               r_state;
    arb_state_t               w_state_next;
    logic [c_PTR_BITS-1:0]    r_grant;
    logic [c_PTR_BITS-1:0]    w_grant_next;
    logic [c_PTR_BITS-1:0]    r_ptr;
    logic [c_PTR_BITS-1:0]    w_ptr_next;
    logic                     r_started;
    logic [c_WD_BITS-1:0]     r_wd;
    logic [c_WD_BITS-1:0]     w_wd_next;
    logic [c_WD_BITS-1:0]     w_wd_inc;
    logic                     r_err;
    logic                     w_err_next;
    logic [NUM_PORTS-1:0]     r_rsp_ready;
    logic [NUM_PORTS-1:0]     w_rsp_ready_next;
    logic [LINE_BITS-1:0]     r_rsp_data;
    logic [LINE_BITS-1:0]     w_rsp_data_next;

    // ------------------------------------------------------------------
    // Per-port field views and the granted port's selection
    // ------------------------------------------------------------------
    logic [ADDRESS_BITS-1:0]  w_addr_arr [NUM_PORTS];
    logic [LINE_BITS-1:0]     w_data_arr [NUM_PORTS];

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
            assign w_addr_arr[p] = req_address_i[p*ADDRESS_BITS +: ADDRESS_BITS];
            assign w_data_arr[p] = req_data_i[p*LINE_BITS +: LINE_BITS];
        end
    endgenerate

    logic                     w_sel_valid;
    logic                     w_sel_write;
    logic [ADDRESS_BITS-1:0]  w_sel_addr;
    logic [LINE_BITS-1:0]     w_sel_data;

    assign w_sel_valid = req_valid_i[r_grant];
    assign w_sel_write = req_write_i[r_grant];
    assign w_sel_addr  = w_addr_arr[r_grant];
    assign w_sel_data  = w_data_arr[r_grant];

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    logic [c_PTR_BITS-1:0]    w_pick;
    logic                     w_pick_any;

    sddr_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_BITS  (c_PTR_BITS)
    ) u_picker (
        .req       (req_valid_i),
        .ptr       (r_ptr),
        .winner    (w_pick),
        .any_valid (w_pick_any)
    );

    // Saturating increment of the response watchdog.
    assign w_wd_inc = (r_wd == {c_WD_BITS{1'b1}}) ? r_wd : r_wd + c_WD_BITS'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_ptr       <= c_PTR_BITS'(NUM_PORTS - 1);
            r_started   <= 1'b0;
            r_wd        <= '0;
            r_err       <= 1'b0;
            r_rsp_ready <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_ptr       <= w_ptr_next;
            r_started   <= 1'b1;
            r_wd        <= w_wd_next;
            r_err       <= w_err_next;
            r_rsp_ready <= w_rsp_ready_next;
            r_rsp_data  <= w_rsp_data_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and downstream command logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        w_ptr_next         = r_ptr;
        w_wd_next          = r_wd;
        w_err_next         = r_err;
        w_rsp_ready_next   = '0;
        w_rsp_data_next    = r_rsp_data;
        req_ack_o          = '0;
        data_cmd_valid_o   = 1'b0;
        data_cmd_write_o   = 1'b0;
        data_cmd_address_o = '0;
        data_cmd_data_o    = '0;

        case (r_state)
            IDLE: begin
                // r_started blocks a grant on the edge that follows reset
                // release, giving the requesters one clean cycle.
                if (r_started && w_pick_any) begin
                    w_grant_next = w_pick;
                    w_ptr_next   = w_pick;
                    w_state_next = ISSUE;
                end
            end

            ISSUE: begin
                if (!w_sel_valid) begin
                    // Requester withdrew before acceptance: drop the command.
                    w_state_next = IDLE;
                end else begin
                    data_cmd_valid_o   = 1'b1;
                    data_cmd_write_o   = w_sel_write;
                    data_cmd_address_o = w_sel_addr;
                    data_cmd_data_o    = w_sel_data;
                    if (data_cmd_ack_i) begin
                        req_ack_o[r_grant] = 1'b1;
                        if (w_sel_write) begin
                            w_state_next = IDLE;
                        end else begin
                            w_wd_next    = '0;
                            w_state_next = WAIT_RSP;
                        end
                    end
                end
            end

            WAIT_RSP: begin
                // A response arriving on the final watchdog cycle still wins.
                if (data_rsp_ready_i) begin
                    w_rsp_data_next           = data_rsp_data_i;
                    w_rsp_ready_next[r_grant] = 1'b1;
                    w_state_next              = IDLE;
                end else begin
                    w_wd_next = w_wd_inc;
                    if (c_WD_ENABLE && (w_wd_inc == c_WD_LIMIT)) begin
                        w_err_next   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    assign rsp_ready_o   = r_rsp_ready;
    assign rsp_data_o    = r_rsp_data;
    assign grant_o       = r_grant;
    assign timeout_err_o = r_err;

endmodule : sddr_port_arbiter
`default_nettype wire
